// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-back arbiter:
// requester index constants and the arbiter FSM state encoding.
package wb_pkg;

  localparam int WB_ALU  = 0;
  localparam int WB_LOAD = 1;
  localparam int WB_CSR  = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } wb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns a one-hot grant for the first set bit
// of mask, searching upward from ptr and wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && mask[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter with lock support feeding the regfile write port.
// Optional decode-bypass outputs fwd_valid/fwd_rd/fwd_data under macro WB_ARB_FWD_EN.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_REQ-1:0]                      req_valid,
  input  logic [NUM_REQ-1:0]                      req_lock,
  input  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0]   req_rd,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]      req_data,
  output logic [NUM_REQ-1:0]                      req_ready,
  output logic                                    WE3,
  output logic [ADDRESS_WIDTH-1:0]                A3,
  output logic [DATA_WIDTH-1:0]                   WD3,
  output logic                                    locked
`ifdef WB_ARB_FWD_EN
  ,
  output logic                                    fwd_valid,
  output logic [ADDRESS_WIDTH-1:0]                fwd_rd,
  output logic [DATA_WIDTH-1:0]                   fwd_data
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  wb_state_e               state_q, state_d;
  logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]           owner_q, owner_d;
  logic                    we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] a3_q, a3_d;
  logic [DATA_WIDTH-1:0]   wd3_q, wd3_d;

  logic [NUM_REQ-1:0]      owner_oh, elig, grant;
  logic                    accept;
  logic [PW-1:0]           gidx, gidx_nxt;
  logic [ADDRESS_WIDTH-1:0] rd_sel;
  logic [DATA_WIDTH-1:0]   data_sel;
  logic                    lock_sel;

  // While locked only the owner is eligible; reset masks every request.
  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    elig              = '0;
    if (rst_n) elig = (state_q == ST_LOCKED) ? (req_valid & owner_oh) : req_valid;
  end

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .mask  (elig),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gidx = PW'(i);
    end
    gidx_nxt = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    rd_sel   = req_rd[gidx];
    data_sel = req_data[gidx];
    lock_sel = req_lock[gidx];
  end

  // Inside LOCKED the grant is always the owner, so gidx+1 keeps rr_ptr at owner+1.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    we_d     = 1'b0;
    a3_d     = a3_q;
    wd3_d    = wd3_q;
    if (accept) begin
      we_d     = (rd_sel != '0);
      a3_d     = rd_sel;
      wd3_d    = data_sel;
      rr_ptr_d = gidx_nxt;
      case (state_q)
        ST_IDLE: begin
          if (lock_sel) begin
            state_d = ST_LOCKED;
            owner_d = gidx;
          end
        end
        ST_LOCKED: begin
          if (!lock_sel) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      we_q     <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
    end
  end

  assign WE3    = we_q;
  assign A3     = a3_q;
  assign WD3    = wd3_q;
  assign locked = (state_q == ST_LOCKED);

`ifdef WB_ARB_FWD_EN
  assign fwd_valid = we_q;
  assign fwd_rd    = a3_q;
  assign fwd_data  = wd3_q;
`endif

endmodule
